// File: rtl/rdata_frame_reader.sv
// Read-side consumer of the prefetch FIFO: pops wide words, unpacks them into
// pixels and emits a valid/ready pixel stream with line and frame markers.
module rdata_frame_reader #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 32,
    parameter int RATIO = 4,
    parameter int H_W   = 12,
    parameter int V_W   = 12
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             frame_start,
    input  logic [H_W-1:0]   h_pixels,
    input  logic [V_W-1:0]   v_lines,
    input  logic [IN_W-1:0]  fifo_rd_data,
    input  logic             fifo_rd_vld,
    output logic             fifo_rd_en,
    output logic [OUT_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_sol,
    output logic             pix_eol,
    output logic             pix_sof,
    output logic             pix_eof,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);

    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IN_W-1:0]   hold_data;
    logic              hold_vld;
    logic [LANE_W-1:0] lane;
    logic [H_W-1:0]    x_cnt;
    logic [H_W-1:0]    h_len;
    logic [V_W-1:0]    y_cnt;
    logic [V_W-1:0]    v_len;

    logic run;
    logic start_ok;
    logic x_last;
    logic y_last;
    logic acc;
    logic wend;
    logic last_acc;
    logic pop;
    logic starve;

    assign run      = (state == RUN);
    assign start_ok = frame_start & (h_pixels != '0) & (v_lines != '0);
    assign x_last   = (x_cnt == h_len - H_W'(1));
    assign y_last   = (y_cnt == v_len - V_W'(1));

    assign pix_valid = run & hold_vld;
    assign acc       = pix_valid & pix_ready;
    // A line end retires the word early; the next line starts on a fresh word.
    assign wend      = acc & ((lane == LANE_LAST) | x_last);
    assign last_acc  = acc & x_last & y_last;

    assign fifo_rd_en = run & (~hold_vld | wend) & ~last_acc;
    assign pop        = fifo_rd_en & fifo_rd_vld;
    assign starve     = run & ~hold_vld & ~fifo_rd_vld & pix_ready;

    always_comb begin
        pix_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == LANE_W'(i)) pix_data = hold_data[i*OUT_W +: OUT_W];
        end
    end

    assign pix_sol = pix_valid & (x_cnt == '0);
    assign pix_eol = pix_valid & x_last;
    assign pix_sof = pix_sol & (y_cnt == '0);
    assign pix_eof = pix_eol & y_last;
    assign busy    = run;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (last_acc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            hold_data  <= '0;
            hold_vld   <= 1'b0;
            lane       <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            h_len      <= '0;
            v_len      <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= last_acc;
            underrun   <= starve;
            if (!run) begin
                if (start_ok) begin
                    h_len    <= h_pixels;
                    v_len    <= v_lines;
                    x_cnt    <= '0;
                    y_cnt    <= '0;
                    lane     <= '0;
                    hold_vld <= 1'b0;
                end
            end else begin
                // Last frame pixel is a word end with the pop suppressed.
                if (pop) begin
                    hold_data <= fifo_rd_data;
                    hold_vld  <= 1'b1;
                    lane      <= '0;
                end else if (wend) begin
                    hold_vld  <= 1'b0;
                end else if (acc) begin
                    lane      <= lane + LANE_W'(1);
                end
                if (acc) begin
                    if (x_last) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + V_W'(1);
                    end else begin
                        x_cnt <= x_cnt + H_W'(1);
                    end
                end
            end
        end
    end

endmodule
